uart_baud_tick_gen: RTL
=======================

// Module: uart_baud_tick_gen
// PURPOSE
//  Parametrised, runtime-programmable UART baud generator: fractional divider -> OVERSAMPLE x baud tick,
//  plus baud-rate tick, mid-bit sample tick and 50% square wave. Feeds uart_tx (baud_tick) and uart_rx
//  (os_tick/mid_tick, rx_resync on start-bit edge). One instance per UART channel.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  input clock frequency, Hz
//  BAUD_RATE   115200      baud rate loaded at reset
//  OVERSAMPLE  16          os_ticks per bit; even, 4..64
//  DIV_W       16          integer divisor width
//  FRAC_W      4           fractional divisor width (1/2^FRAC_W cycle resolution)
//  Reset divisor D = round(CLOCK_FREQ*2^FRAC_W/(BAUD_RATE*OVERSAMPLE)); int = D>>FRAC_W, frac = D low bits
//  (defaults: 434 -> int 27, frac 2)
// PORTS
//  clk        in   1       clock
//  reset      in   1       asynchronous, active-high reset
//  enable     in   1       1 = run; 0 = freeze counters, all tick outputs 0
//  div_int    in   DIV_W   integer cycles per os_tick; legal >= 2
//  div_frac   in   FRAC_W  fractional part, units of 1/2^FRAC_W cycle
//  div_load   in   1       1-cycle strobe: capture div_int/div_frac into pending register
//  rx_resync  in   1       1-cycle strobe: restart bit phase (start-bit edge detected)
//  os_tick    out  1       1-cycle pulse per oversample period
//  baud_tick  out  1       1-cycle pulse, os_tick at phase OVERSAMPLE-1 (bit boundary)
//  mid_tick   out  1       1-cycle pulse, os_tick at phase OVERSAMPLE/2-1 (bit centre)
//  baud_clk   out  1       square wave at baud rate, toggles on baud_tick and mid_tick
//  div_err    out  1       1 while active div_int < 2; ticks suppressed
// BEHAVIOUR
//  - Reset: cnt=0, ph=0, acc=0, active=pending=reset divisor, pend_valid=0, all outputs 0. Mid-op reset aborts all.
//  - Period P = div_int + carry, carry latched from previous os_tick. os_tick is combinational,
//    = enable & ~div_err & ~rx_resync & (cnt == P-1); cnt -> 0 on os_tick, else +1 while enabled.
//  - On os_tick: {carry,acc} <= acc + div_frac (FRAC_W+1 bits); ph <= (ph==OVERSAMPLE-1) ? 0 : ph+1.
//  - baud_tick = os_tick & ph==OVERSAMPLE-1; mid_tick = os_tick & ph==OVERSAMPLE/2-1; same cycle as os_tick.
//  - baud_clk registered: toggles cycle after baud_tick/mid_tick; reset 0.
//  - div_load: pending <= inputs, pend_valid=1. Pending -> active on next os_tick, on rx_resync, or
//    immediately if enable==0 or div_err==1. Repeated loads before transfer: last wins.
//  - rx_resync: cnt=0, ph=0, acc=0, carry=0; os_tick suppressed that cycle; first mid_tick
//    OVERSAMPLE/2 os_ticks later. Resync+load same cycle: new divisor used from the next cycle.
//  - enable=0: cnt/ph/acc/carry hold, baud_clk holds; resume continues exactly where frozen.
//  - div_err = active div_int < 2 (registered from active); while set cnt/ph held at 0, no ticks.
//  - Active divisor changes: cnt kept; if cnt >= new P-1, os_tick fires next cycle (no 2^DIV_W wrap).
//  - cnt width DIV_W; P-1 <= 2^DIV_W-1 always fits.
// STRUCTURE
//  - uart_pkg: OVERSAMPLE_DEF, DIV_W/FRAC_W defaults, typedef div_t {int, frac},
//    function calc_div(clk_hz, baud, os) returning div_t.
//  - Sub-module uart_frac_divider: cnt, acc, carry, os_tick, div_err. Top adds phase counter,
//    load/resync control, baud/mid ticks, baud_clk.
// TESTING
//  - Reset defaults, enable=1: os_tick periods 27 x7 then 28, repeating; baud_tick every 16th os_tick (434 clk avg/16).
//  - div_load int=4 frac=0 mid-period: switch at next os_tick; then period 4, baud_tick every 64 clk.
//  - rx_resync at arbitrary cycle (int=4,frac=0): no os_tick that cycle; mid_tick 32 clk later, baud_tick 64 clk later.
//  - enable low 100 clk mid-bit: no ticks, baud_clk holds; resumes with remaining count intact.
//  - div_int=1 load with enable=0: immediate, div_err=1, no ticks; load int=8 -> div_err=0 next cycle.
//  - Assert reset mid-bit with pending load: all outputs 0 same cycle; after release periods revert to 27/28.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults, divisor type and reset-divisor calculation for the UART baud generator.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DIV_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 4;

  typedef struct packed {
    logic [31:0] int_part;
    logic [31:0] frac_part;
  } div_t;

  // Rounded fixed-point divisor clk_hz*2^frac_w / (baud*os), split into integer and fraction.
  function automatic div_t calc_div(input longint clk_hz, input longint baud,
                                    input longint os, input int frac_w = FRAC_W_DEF);
    longint num;
    longint den;
    longint d;
    div_t   r;
    num = clk_hz << frac_w;
    den = baud * os;
    d   = (2 * num + den) / (2 * den);
    r.int_part  = 32'(d >> frac_w);
    r.frac_part = 32'(d & ((longint'(1) << frac_w) - 1));
    return r;
  endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// Fractional clock divider: holds the active divisor and produces one os_tick per
// div_int + carry cycles, with the carry accumulated from div_frac.
module uart_frac_divider #(
  parameter int                DIV_W    = 16,
  parameter int                FRAC_W   = 4,
  parameter logic [DIV_W-1:0]  RST_INT  = '0,
  parameter logic [FRAC_W-1:0] RST_FRAC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              resync,
  input  logic              set_div,
  input  logic [DIV_W-1:0]  set_int,
  input  logic [FRAC_W-1:0] set_frac,
  output logic              os_tick,
  output logic              div_err
);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [DIV_W:0]    per_m1;

  // One bit wider than cnt so the period never wraps; >= lets a shrunken divisor fire at once.
  always_comb begin
    per_m1  = {1'b0, act_int} + (DIV_W+1)'(carry) - (DIV_W+1)'(1);
    os_tick = enable & ~div_err & ~resync & ({1'b0, cnt} >= per_m1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      act_int  <= RST_INT;
      act_frac <= RST_FRAC;
      div_err  <= (RST_INT < DIV_W'(2));
    end else begin
      if (set_div) begin
        act_int  <= set_int;
        act_frac <= set_frac;
        div_err  <= (set_int < DIV_W'(2));
      end
      if (resync) begin
        cnt   <= '0;
        acc   <= '0;
        carry <= 1'b0;
      end else if (div_err) begin
        cnt <= '0;
      end else if (os_tick) begin
        cnt          <= '0;
        {carry, acc} <= {1'b0, acc} + {1'b0, act_frac};
      end else if (enable) begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// Programmable UART baud generator: oversample tick, bit-boundary and bit-centre ticks,
// and a baud-rate square wave, with deferred divisor loading and start-bit resync.
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              rx_resync,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              mid_tick,
  output logic              baud_clk,
  output logic              div_err
);

  localparam div_t              RST_DIV  = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE, FRAC_W);
  localparam logic [DIV_W-1:0]  RST_INT  = RST_DIV.int_part[DIV_W-1:0];
  localparam logic [FRAC_W-1:0] RST_FRAC = RST_DIV.frac_part[FRAC_W-1:0];
  localparam int                PH_W     = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]   PH_MID   = PH_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] pend_frac;
  logic              pend_valid;
  logic [PH_W-1:0]   ph;
  logic              xfer_ok;
  logic              set_div;
  logic [DIV_W-1:0]  set_int;
  logic [FRAC_W-1:0] set_frac;

  uart_frac_divider #(
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .RST_INT  (RST_INT),
    .RST_FRAC (RST_FRAC)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .resync   (rx_resync),
    .set_div  (set_div),
    .set_int  (set_int),
    .set_frac (set_frac),
    .os_tick  (os_tick),
    .div_err  (div_err)
  );

  // A new divisor may only take over at a period boundary, unless nothing is counting.
  always_comb begin
    xfer_ok  = os_tick | rx_resync | ~enable | div_err;
    set_div  = pend_valid & xfer_ok;
    set_int  = pend_int;
    set_frac = pend_frac;
    if (div_load) begin
      set_div  = xfer_ok;
      set_int  = div_int;
      set_frac = div_frac;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_int   <= RST_INT;
      pend_frac  <= RST_FRAC;
      pend_valid <= 1'b0;
    end else if (div_load) begin
      pend_int   <= div_int;
      pend_frac  <= div_frac;
      pend_valid <= ~xfer_ok;
    end else if (set_div) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph <= '0;
    end else if (rx_resync || div_err) begin
      ph <= '0;
    end else if (os_tick) begin
      ph <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);
    end
  end

  always_comb begin
    baud_tick = os_tick & (ph == PH_LAST);
    mid_tick  = os_tick & (ph == PH_MID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_clk <= 1'b0;
    end else if (baud_tick || mid_tick) begin
      baud_clk <= ~baud_clk;
    end
  end

endmodule
